// File: rtl/iiitb_coin_sequencer.sv
// Coin sequencer: synchronises and debounces two coin sensors, holds one purchase in a
// 3-entry FIFO and replays it as a gap-free burst. IIITB_COIN_AUDIT_EN adds audit_total_o.
module iiitb_coin_sequencer #(
   parameter int unsigned DebCycles     = 16,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        coin5_raw_i,
   input  logic        coin10_raw_i,
   input  logic        cancel_i,
   output logic [1:0]  vm_in_o,
   output logic        busy_o,
`ifdef IIITB_COIN_AUDIT_EN
   output logic [15:0] audit_total_o,
`endif
   output logic        coin_reject_o
);

   localparam int unsigned DebW = $clog2(DebCycles + 1);
   localparam int unsigned TmrW = $clog2(TimeoutCycles);

   typedef enum logic [1:0] {StIdle, StCollect, StBurst, StGap} state_e;

   // Channel 0 is the five sensor, channel 1 the ten sensor.
   logic [1:0]      sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, ev;
   logic [DebW-1:0] cnt_q [2];
   logic [DebW-1:0] cnt_d [2];

   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         deb_d[ch] = deb_q[ch];
         if (sync2_q[ch] == deb_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == DebW'(DebCycles)) begin
            deb_d[ch] = ~deb_q[ch];
            cnt_d[ch] = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + DebW'(1);
         end
      end
   end

   assign ev = deb_q & ~deb_dly_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         cnt_q     <= '{default: '0};
      end else begin
         sync1_q   <= {coin10_raw_i, coin5_raw_i};
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         cnt_q     <= cnt_d;
      end
   end

   state_e          state_q, state_d;
   logic [1:0]      fifo_q [3];
   logic [1:0]      fifo_d [3];
   logic [1:0]      count_q, count_d;
   logic [2:0]      sum_q, sum_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [1:0]      vm_q, vm_d;
   logic            reject_q, reject_d;
   logic            open_win, push;
   logic [1:0]      code;

   assign open_win = (state_q == StIdle) || (state_q == StCollect);
   assign push     = ((ev == 2'b01) || (ev == 2'b10)) && open_win && (count_q != 2'd3);
   assign reject_d = (ev != 2'b00) && !push;
   // Code value doubles as the coin value in units of five.
   assign code     = ev[1] ? 2'b10 : 2'b01;

   always_comb begin
      state_d = state_q;
      fifo_d  = fifo_q;
      count_d = count_q;
      sum_d   = sum_q;
      timer_d = timer_q;
      vm_d    = 2'b00;
      if (push) begin
         fifo_d[count_q] = code;
         count_d         = count_q + 2'd1;
         sum_d           = sum_q + {1'b0, code};
      end
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (push) state_d = StCollect;
         end
         StCollect: begin
            timer_d = push ? '0 : timer_q + TmrW'(1);
            // A coin arriving with cancel is already pushed above before the burst starts.
            if ((sum_d >= 3'd3) || (timer_q == TmrW'(TimeoutCycles - 1)) || cancel_i) begin
               state_d = StBurst;
            end
         end
         StBurst: begin
            sum_d   = '0;
            timer_d = '0;
            if (count_q != 2'd0) begin
               vm_d      = fifo_q[0];
               fifo_d[0] = fifo_q[1];
               fifo_d[1] = fifo_q[2];
               fifo_d[2] = 2'b00;
               count_d   = count_q - 2'd1;
            end else begin
               state_d = StGap;
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         fifo_q   <= '{default: 2'b00};
         count_q  <= '0;
         sum_q    <= '0;
         timer_q  <= '0;
         vm_q     <= 2'b00;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fifo_q   <= fifo_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         timer_q  <= timer_d;
         vm_q     <= vm_d;
         reject_q <= reject_d;
      end
   end

   assign vm_in_o       = vm_q;
   assign busy_o        = (state_q == StBurst) || (state_q == StGap);
   assign coin_reject_o = reject_q;

`ifdef IIITB_COIN_AUDIT_EN
   logic [15:0] audit_q;
   logic [16:0] audit_sum;

   assign audit_sum = {1'b0, audit_q} + {15'd0, vm_d};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         audit_q <= '0;
      end else begin
         audit_q <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
      end
   end

   assign audit_total_o = audit_q;
`endif

endmodule

// File: tb/tb_iiitb_coin_sequencer.sv
// Bench for iiitb_coin_sequencer: scoreboard of expected burst codes against observed vm_in.
module tb_iiitb_coin_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       c5 = 1'b0;
   logic       c10 = 1'b0;
   logic       cancel = 1'b0;
   logic [1:0] vm;
   logic       busy;
   logic       rej;
`ifdef IIITB_COIN_AUDIT_EN
   logic [15:0] audit;
`endif

   int errors = 0;
   int checks = 0;
   logic [1:0] exp_q [$];
   logic [1:0] obs_q [$];
   int         obs_t [$];
   int cyc = 0;
   int busy_cnt = 0;
   int rej_cnt = 0;
   int audit_model = 0;

   always #5 clk_i = ~clk_i;

   iiitb_coin_sequencer dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .coin5_raw_i  (c5),
      .coin10_raw_i (c10),
      .cancel_i     (cancel),
      .vm_in_o      (vm),
      .busy_o       (busy),
`ifdef IIITB_COIN_AUDIT_EN
      .audit_total_o(audit),
`endif
      .coin_reject_o(rej)
   );

   // Monitor: records every emitted code with its cycle number.
   always @(negedge clk_i) begin
      cyc = cyc + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (rej) rej_cnt = rej_cnt + 1;
      if (!rst_ni) audit_model = 0;
      else audit_model = audit_model + int'(vm);
      if (vm != 2'b00) begin
         obs_q.push_back(vm);
         obs_t.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic nstep(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic set_raw(input logic ten, input logic v);
      if (ten) c10 = v;
      else c5 = v;
   endtask

   task automatic press(input logic ten, input int hold, input bit bounce);
      if (bounce) begin
         repeat (3) begin
            set_raw(ten, 1'b1); nstep(1);
            set_raw(ten, 1'b0); nstep(1);
         end
      end
      set_raw(ten, 1'b1);
      nstep(hold);
      set_raw(ten, 1'b0);
   endtask

   task automatic clear();
      exp_q.delete();
      obs_q.delete();
      obs_t.delete();
      busy_cnt = 0;
      rej_cnt = 0;
   endtask

   task automatic wait_idle(input int budget, output bit to);
      int k = 0;
      to = 1'b0;
      while (!(busy_cnt > 0 && busy == 1'b0)) begin
         nstep(1);
         k++;
         if (k > budget) begin
            to = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nstep(3);
      checks++; if (vm !== 2'b00) begin errors++; $display("FAIL reset_vm: got %b want 00", vm); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rej !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b want 0", rej); end
      rst_ni = 1'b1;
      nstep(5);
      checks++; if (vm !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got vm=%b busy=%b want 00/0", vm, busy);
      end
   endtask

   // Bounced coins, then a clean final coin whose raw rise is timed to the first code.
   task automatic test_full_purchase(input string name, input int n, input logic [2:0] tens);
      bit to;
      int lat;
      logic [1:0] e, o;
      clear();
      for (int i = 0; i < n; i++) exp_q.push_back(tens[i] ? 2'b10 : 2'b01);
      for (int i = 0; i < n - 1; i++) begin
         press(tens[i], 24, 1'b1);
         nstep(30);
      end
      set_raw(tens[n-1], 1'b1);
      lat = 0;
      while (vm == 2'b00 && lat < 40) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checks++; if (lat !== 21) begin
         errors++; $display("FAIL %s_latency: got %0d cycles want 21", name, lat);
      end
      nstep(5);
      set_raw(tens[n-1], 1'b0);
      wait_idle(100, to);
      checks++; if (to) begin errors++; $display("FAIL %s_idle: busy never cleared", name); end
      checks++; if (obs_q.size() != n) begin
         errors++; $display("FAIL %s_count: got %0d codes want %0d", name, obs_q.size(), n);
      end
      for (int i = 1; i < obs_t.size(); i++) begin
         checks++; if (obs_t[i] !== obs_t[0] + i) begin
            errors++; $display("FAIL %s_gapfree: code %0d at cycle %0d want %0d", name, i, obs_t[i],
                               obs_t[0] + i);
         end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL %s_code: got %b want %b", name, o, e); end
      end
      checks++; if (busy_cnt !== n + 2) begin
         errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, busy_cnt, n + 2);
      end
      checks++; if (vm !== 2'b00) begin errors++; $display("FAIL %s_tail: got %b want 00", name, vm); end
      nstep(30);
   endtask

   task automatic test_timeout();
      bit to;
      logic [1:0] o;
      clear();
      press(1'b0, 24, 1'b1);
      nstep(900);
      checks++; if (busy_cnt !== 0) begin
         errors++; $display("FAIL timeout_early: busy for %0d cycles want 0", busy_cnt);
      end
      wait_idle(400, to);
      checks++; if (to) begin errors++; $display("FAIL timeout_idle: no flush seen"); end
      checks++; if (obs_q.size() != 1) begin
         errors++; $display("FAIL timeout_count: got %0d codes want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++; if (o !== 2'b01) begin errors++; $display("FAIL timeout_code: got %b want 01", o); end
      end
      nstep(10);
   endtask

   task automatic test_cancel();
      bit to;
      logic [1:0] o;
      clear();
      press(1'b1, 24, 1'b1);
      nstep(10);
      cancel = 1'b1; nstep(1); cancel = 1'b0;
      wait_idle(20, to);
      checks++; if (to || obs_q.size() != 1) begin
         errors++; $display("FAIL cancel_count: got %0d codes want 1 (timeout=%0d)", obs_q.size(), to);
      end else begin
         o = obs_q.pop_front();
         checks++; if (o !== 2'b10) begin errors++; $display("FAIL cancel_code: got %b want 10", o); end
      end
      checks++; if (busy_cnt !== 3) begin
         errors++; $display("FAIL cancel_busy_len: got %0d want 3", busy_cnt);
      end
      nstep(30);
   endtask

   task automatic test_glitch();
      clear();
      c5 = 1'b1; nstep(14); c5 = 1'b0;
      nstep(60);
      checks++; if (busy_cnt !== 0 || rej_cnt !== 0) begin
         errors++; $display("FAIL glitch_quiet: busy=%0d reject=%0d want 0/0", busy_cnt, rej_cnt);
      end
      test_full_purchase("after_glitch", 2, 3'b011);
   endtask

   task automatic test_both();
      clear();
      c5 = 1'b1; c10 = 1'b1;
      nstep(24);
      c5 = 1'b0; c10 = 1'b0;
      nstep(40);
      checks++; if (rej_cnt !== 1) begin
         errors++; $display("FAIL both_reject: got %0d pulses want 1", rej_cnt);
      end
      checks++; if (busy_cnt !== 0) begin
         errors++; $display("FAIL both_busy: got %0d busy cycles want 0", busy_cnt);
      end
      test_full_purchase("after_both", 2, 3'b011);
   endtask

   task automatic test_busy_reject();
      bit to;
      logic [1:0] e, o;
      clear();
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b01);
      press(1'b1, 24, 1'b1);
      nstep(30);
      fork
         press(1'b0, 24, 1'b0);
         begin nstep(2); press(1'b1, 24, 1'b0); end
      join
      wait_idle(60, to);
      checks++; if (to) begin errors++; $display("FAIL busyrej_idle: busy never cleared"); end
      checks++; if (rej_cnt !== 1) begin
         errors++; $display("FAIL busyrej_reject: got %0d pulses want 1", rej_cnt);
      end
      checks++; if (obs_q.size() != 2) begin
         errors++; $display("FAIL busyrej_count: got %0d codes want 2", obs_q.size());
      end
      checks++; if (obs_t.size() == 2 && obs_t[1] !== obs_t[0] + 1) begin
         errors++; $display("FAIL busyrej_gapfree: codes at %0d and %0d", obs_t[0], obs_t[1]);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL busyrej_code: got %b want %b", o, e); end
      end
      nstep(40);
   endtask

   task automatic test_reset_mid_burst();
      int k;
      clear();
      press(1'b0, 24, 1'b1); nstep(30);
      press(1'b0, 24, 1'b1); nstep(30);
      c5 = 1'b1;
      k = 0;
      while (vm == 2'b00 && k < 60) begin nstep(1); k++; end
      checks++; if (vm !== 2'b01) begin errors++; $display("FAIL midrst_burst: got %b want 01", vm); end
      rst_ni = 1'b0;
      c5 = 1'b0;
      #1;
      checks++; if (vm !== 2'b00) begin errors++; $display("FAIL midrst_vm: got %b want 00", vm); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      nstep(2);
      rst_ni = 1'b1;
      nstep(40);
      checks++; if (vm !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_release: got vm=%b busy=%b want 00/0", vm, busy);
      end
      test_full_purchase("after_midrst", 2, 3'b011);
   endtask

   initial begin
      test_reset();
      test_full_purchase("ten_five", 2, 3'b001);
      test_full_purchase("three_five", 3, 3'b000);
      test_full_purchase("two_ten", 2, 3'b011);
      test_timeout();
      test_cancel();
      test_glitch();
      test_both();
      test_busy_reject();
      test_reset_mid_burst();
`ifdef IIITB_COIN_AUDIT_EN
      checks++; if (audit !== 16'(audit_model)) begin
         errors++; $display("FAIL audit_total: got %0d want %0d", audit, audit_model);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
